// File: rtl/uart_pkg.sv
// Shared UART constants and types: interrupt source layout and the 32-bit IRQ register view.
package uart_pkg;

  localparam int         IRQ_NUM_SRC        = 9;
  localparam logic [8:0] IRQ_LEVEL_SRC_MASK = 9'h028;

  localparam int IRQ_TX_DONE        = 0;
  localparam int IRQ_RX_DONE        = 1;
  localparam int IRQ_DFIFO_FULL     = 2;
  localparam int IRQ_DFIFO_EMPTY    = 3;
  localparam int IRQ_UFIFO_FULL     = 4;
  localparam int IRQ_UFIFO_NOT_EMPTY = 5;
  localparam int IRQ_UART_PARITY    = 6;
  localparam int IRQ_UART_OVERRUN   = 7;
  localparam int IRQ_UART_BAD_FRAME = 8;

  typedef struct packed {
    logic [22:0]            rsvd;
    logic [IRQ_NUM_SRC-1:0] bits;
  } uart_irq_regs_t;

  // Upper bits of the bus view always read as zero.
  function automatic uart_irq_regs_t irq_reg_view(input logic [IRQ_NUM_SRC-1:0] bits);
    uart_irq_regs_t v;
    v.rsvd = '0;
    v.bits = bits;
    return v;
  endfunction

endpackage

// File: rtl/uart_irq_edge_det.sv
// Turns raw UART event sources into single-cycle triggers: level sources on their rising edge, pulse sources as-is.
module uart_irq_edge_det
  import uart_pkg::*;
#(
  parameter int                 NUM_SRC   = IRQ_NUM_SRC,
  parameter logic [NUM_SRC-1:0] LEVEL_SRC = IRQ_LEVEL_SRC_MASK
) (
  input  logic               pclk,
  input  logic               presetn,
  input  logic [NUM_SRC-1:0] src_i,
  output logic [NUM_SRC-1:0] trig_o
);

  logic [NUM_SRC-1:0] r_src_q;
  logic [NUM_SRC-1:0] w_rise;

  // Cleared by reset so a level source already high at release counts as an edge.
  always_ff @(posedge pclk) begin
    if (!presetn) r_src_q <= '0;
    else          r_src_q <= src_i;
  end

  assign w_rise = src_i & ~r_src_q;
  assign trig_o = (LEVEL_SRC & w_rise) | (~LEVEL_SRC & src_i);

endmodule

// File: rtl/uart_irq_ctrl.sv
// UART interrupt controller: enable/mask registers, sticky W1C event register and a registered host IRQ line.
module uart_irq_ctrl
  import uart_pkg::*;
#(
  parameter int                 NUM_SRC   = IRQ_NUM_SRC,
  parameter logic [NUM_SRC-1:0] LEVEL_SRC = IRQ_LEVEL_SRC_MASK
) (
  input  logic               pclk,
  input  logic               presetn,
  input  logic [NUM_SRC-1:0] src_i,
  input  logic               en_wr_i,
  input  logic               mask_wr_i,
  input  logic               evt_clr_i,
  input  logic [NUM_SRC-1:0] wdata_i,
  output logic [NUM_SRC-1:0] irq_en_o,
  output logic [NUM_SRC-1:0] irq_mask_o,
  output logic [NUM_SRC-1:0] irq_event_o,
  output logic               irq_o
);

  logic [NUM_SRC-1:0] r_en;
  logic [NUM_SRC-1:0] r_mask;
  logic [NUM_SRC-1:0] r_event;
  logic               r_irq;

  logic [NUM_SRC-1:0] w_trig;
  logic [NUM_SRC-1:0] w_clr;
  logic [NUM_SRC-1:0] w_event_nxt;
  logic [NUM_SRC-1:0] w_mask_nxt;

  uart_irq_edge_det #(
    .NUM_SRC   (NUM_SRC),
    .LEVEL_SRC (LEVEL_SRC)
  ) u_edge_det (
    .pclk    (pclk),
    .presetn (presetn),
    .src_i   (src_i),
    .trig_o  (w_trig)
  );

  // Set wins over clear; triggers are gated by the enable value before any same-cycle write.
  assign w_clr       = evt_clr_i ? wdata_i : '0;
  assign w_event_nxt = (r_event & ~w_clr) | (w_trig & r_en);
  assign w_mask_nxt  = mask_wr_i ? wdata_i : r_mask;

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      r_en    <= '0;
      r_mask  <= '0;
      r_event <= '0;
      r_irq   <= 1'b0;
    end else begin
      if (en_wr_i)   r_en   <= wdata_i;
      if (mask_wr_i) r_mask <= wdata_i;
      r_event <= w_event_nxt;
      r_irq   <= |(w_event_nxt & ~w_mask_nxt);
    end
  end

  assign irq_en_o    = r_en;
  assign irq_mask_o  = r_mask;
  assign irq_event_o = r_event;
  assign irq_o       = r_irq;

endmodule

// File: tb/tb_uart_irq_ctrl.sv
// Directed bench for uart_irq_ctrl with a per-cycle behavioural reference and literal spot checks.
module tb_uart_irq_ctrl;

  localparam int         N     = 9;
  localparam logic [8:0] LEVEL = 9'h028;

  logic         pclk = 1'b0;
  logic         presetn;
  logic [N-1:0] src_i;
  logic         en_wr_i, mask_wr_i, evt_clr_i;
  logic [N-1:0] wdata_i;
  logic [N-1:0] irq_en_o, irq_mask_o, irq_event_o;
  logic         irq_o;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_on  = 1'b0;

  bit [N-1:0] m_en, m_mask, m_ev, m_prev;
  bit         m_irq;

  uart_irq_ctrl #(.NUM_SRC(N), .LEVEL_SRC(LEVEL)) dut (
    .pclk        (pclk),
    .presetn     (presetn),
    .src_i       (src_i),
    .en_wr_i     (en_wr_i),
    .mask_wr_i   (mask_wr_i),
    .evt_clr_i   (evt_clr_i),
    .wdata_i     (wdata_i),
    .irq_en_o    (irq_en_o),
    .irq_mask_o  (irq_mask_o),
    .irq_event_o (irq_event_o),
    .irq_o       (irq_o)
  );

  always #5 pclk = ~pclk;

  // Reference: sticky per-source event bits, set by an enabled trigger, cleared by W1C, set winning.
  always @(posedge pclk) begin
    bit [N-1:0] nev;
    if (!presetn) begin
      m_en = '0; m_mask = '0; m_ev = '0; m_prev = '0; m_irq = 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        bit fired;
        fired = LEVEL[i] ? (src_i[i] && !m_prev[i]) : src_i[i];
        if (fired && m_en[i])             nev[i] = 1'b1;
        else if (evt_clr_i && wdata_i[i]) nev[i] = 1'b0;
        else                              nev[i] = m_ev[i];
      end
      m_ev = nev;
      if (en_wr_i)   m_en   = wdata_i;
      if (mask_wr_i) m_mask = wdata_i;
      m_prev = src_i;
      m_irq  = 1'b0;
      for (int i = 0; i < N; i++) if (m_ev[i] && !m_mask[i]) m_irq = 1'b1;
    end
  end

  always @(negedge pclk) begin
    if (chk_on) begin
      n_total++;
      if (irq_en_o === m_en && irq_mask_o === m_mask && irq_event_o === m_ev && irq_o === m_irq)
        n_pass++;
      else
        $display("FAIL model t=%0t got en=%h mask=%h ev=%h irq=%b want en=%h mask=%h ev=%h irq=%b",
                 $time, irq_en_o, irq_mask_o, irq_event_o, irq_o, m_en, m_mask, m_ev, m_irq);
    end
  end

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s got %h want %h", name, act, exp);
  endtask

  // Apply one cycle of inputs; returns 1 time unit after the edge that consumed them.
  task automatic drive(input logic [N-1:0] s, input logic ew, input logic mw,
                       input logic cl, input logic [N-1:0] wd);
    src_i = s; en_wr_i = ew; mask_wr_i = mw; evt_clr_i = cl; wdata_i = wd;
    @(posedge pclk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    presetn = 1'b0;
    drive(9'h1FF, 1, 1, 1, 9'h1FF);
    drive(9'h000, 0, 0, 0, 9'h000);
    chk_on = 1'b1;
    chk("rst_en", irq_en_o, 9'h000);
    chk("rst_mask", irq_mask_o, 9'h000);
    chk("rst_ev", irq_event_o, 9'h000);
    chk("rst_irq", {8'h0, irq_o}, 9'h000);
    presetn = 1'b1;

    // Pulse tx_done, then clear it.
    drive(9'h000, 1, 0, 0, 9'h1FF);
    drive(9'h000, 0, 1, 0, 9'h000);
    chk("en_load", irq_en_o, 9'h1FF);
    drive(9'h001, 0, 0, 0, 9'h000);
    chk("tx_ev", irq_event_o, 9'h001);
    chk("tx_irq", {8'h0, irq_o}, 9'h001);
    drive(9'h000, 0, 0, 1, 9'h001);
    chk("tx_clr_ev", irq_event_o, 9'h000);
    chk("tx_clr_irq", {8'h0, irq_o}, 9'h000);

    // Level source held high: one capture, W1C while high sticks at 0, low-high recaptures.
    drive(9'h000, 1, 0, 0, 9'h020);
    drive(9'h020, 0, 0, 0, 9'h000);
    chk("lvl_cap", irq_event_o, 9'h020);
    drive(9'h020, 0, 0, 1, 9'h020);
    chk("lvl_w1c", irq_event_o, 9'h000);
    for (int k = 0; k < 8; k++) drive(9'h020, 0, 0, 0, 9'h000);
    chk("lvl_held", irq_event_o, 9'h000);
    drive(9'h000, 0, 0, 0, 9'h000);
    drive(9'h020, 0, 0, 0, 9'h000);
    chk("lvl_recap", irq_event_o, 9'h020);
    chk("lvl_irq", {8'h0, irq_o}, 9'h001);
    drive(9'h000, 0, 0, 1, 9'h1FF);

    // Set beats clear on rx_done.
    drive(9'h000, 1, 0, 0, 9'h1FF);
    drive(9'h002, 0, 0, 1, 9'h002);
    chk("prio_ev", irq_event_o, 9'h002);
    chk("prio_irq", {8'h0, irq_o}, 9'h001);
    drive(9'h000, 0, 0, 1, 9'h1FF);

    // Masked bad_frame stays latched; unmask raises irq.
    drive(9'h000, 0, 1, 0, 9'h100);
    drive(9'h100, 0, 0, 0, 9'h000);
    chk("mask_ev", irq_event_o, 9'h100);
    chk("mask_irq", {8'h0, irq_o}, 9'h000);
    drive(9'h000, 0, 1, 0, 9'h000);
    chk("unmask_irq", {8'h0, irq_o}, 9'h001);
    drive(9'h000, 0, 0, 1, 9'h1FF);

    // Disabled sources, and an enable write coinciding with the pulse.
    drive(9'h000, 1, 0, 0, 9'h000);
    drive(9'h1FF, 0, 0, 0, 9'h000);
    chk("dis_ev", irq_event_o, 9'h000);
    drive(9'h000, 0, 0, 0, 9'h000);
    drive(9'h1FF, 1, 0, 0, 9'h1FF);
    chk("en_same_cyc", irq_event_o, 9'h000);
    chk("en_same_reg", irq_en_o, 9'h1FF);
    drive(9'h000, 0, 0, 0, 9'h000);

    // Reset wipes latched events; level source high at release is not captured while disabled.
    drive(9'h0FF, 0, 0, 0, 9'h000);
    chk("pre_rst_ev", irq_event_o, 9'h0FF);
    presetn = 1'b0;
    drive(9'h008, 1, 1, 0, 9'h1FF);
    chk("rst2_ev", irq_event_o, 9'h000);
    chk("rst2_en", irq_en_o, 9'h000);
    chk("rst2_irq", {8'h0, irq_o}, 9'h000);
    presetn = 1'b1;
    drive(9'h008, 0, 0, 0, 9'h000);
    chk("rel_dfifo", irq_event_o, 9'h000);
    drive(9'h008, 1, 0, 0, 9'h008);
    drive(9'h008, 0, 0, 0, 9'h000);
    chk("rel_held", irq_event_o, 9'h000);

    @(negedge pclk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
